// File: rtl/ident_8b_uart_top.sv
// UART 8N1 byte-echo loopback: receive a byte, pass it through an 8-bit identity
// stage and transmit it back, with an active-low clear-to-send output.
module ident_8b_uart_top #(
  parameter int ClocksPerBaud = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic tx_out,
  output logic clear_to_send_out_n
);

  localparam int CntW = $clog2(ClocksPerBaud);
  localparam logic [CntW-1:0] BaudLast = CntW'(ClocksPerBaud - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(ClocksPerBaud / 2 - 1);

  typedef enum logic [2:0] {
    RCV_IDLE, RCV_START, RCV_DATA, RCV_STOP, RCV_RECOVER
  } rcv_state_e;

  typedef enum logic [1:0] {
    RX_WAIT, COMPUTE, TX_START, TX_WAIT
  } ctrl_state_e;

  // Input synchronizer plus one history flop for start-edge detection
  logic rx_meta_q, rx_sync_q, rx_prev_q;

  rcv_state_e      rcv_state_q, rcv_state_d;
  logic [CntW-1:0] rcv_cnt_q, rcv_cnt_d;
  logic [2:0]      rcv_bit_q, rcv_bit_d;
  logic [7:0]      rcv_shift_q, rcv_shift_d;
  logic [7:0]      rx_byte_q, rx_byte_d;
  logic            rx_done_q, rx_done_d;

  ctrl_state_e     state_q, state_d;
  logic [7:0]      byte_q, byte_d;
  logic [7:0]      result_q, result_d;
  logic            cts_n_q, cts_n_d;
  logic            tx_start;

  logic            tx_busy_q, tx_busy_d;
  logic            tx_out_q, tx_out_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic [7:0]      tx_shift_q, tx_shift_d;
  logic            tx_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q   <= 1'b1;
      rx_sync_q   <= 1'b1;
      rx_prev_q   <= 1'b1;
      rcv_state_q <= RCV_IDLE;
      rcv_cnt_q   <= '0;
      rcv_bit_q   <= '0;
      rcv_shift_q <= '0;
      rx_byte_q   <= '0;
      rx_done_q   <= 1'b0;
      state_q     <= RX_WAIT;
      byte_q      <= '0;
      result_q    <= '0;
      cts_n_q     <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_out_q    <= 1'b1;
      tx_cnt_q    <= '0;
      tx_bit_q    <= '0;
      tx_shift_q  <= '0;
    end else begin
      rx_meta_q   <= rx_in;
      rx_sync_q   <= rx_meta_q;
      rx_prev_q   <= rx_sync_q;
      rcv_state_q <= rcv_state_d;
      rcv_cnt_q   <= rcv_cnt_d;
      rcv_bit_q   <= rcv_bit_d;
      rcv_shift_q <= rcv_shift_d;
      rx_byte_q   <= rx_byte_d;
      rx_done_q   <= rx_done_d;
      state_q     <= state_d;
      byte_q      <= byte_d;
      result_q    <= result_d;
      cts_n_q     <= cts_n_d;
      tx_busy_q   <= tx_busy_d;
      tx_out_q    <= tx_out_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_bit_q    <= tx_bit_d;
      tx_shift_q  <= tx_shift_d;
    end
  end

  // Receiver: mid-bit sampling, false-start rejection, framing-error recovery
  always_comb begin
    rcv_state_d = rcv_state_q;
    rcv_cnt_d   = rcv_cnt_q;
    rcv_bit_d   = rcv_bit_q;
    rcv_shift_d = rcv_shift_q;
    rx_byte_d   = rx_byte_q;
    rx_done_d   = 1'b0;
    unique case (rcv_state_q)
      RCV_IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          rcv_state_d = RCV_START;
          rcv_cnt_d   = '0;
        end
      end
      RCV_START: begin
        if (rcv_cnt_q == HalfLast) begin
          rcv_cnt_d   = '0;
          rcv_bit_d   = '0;
          rcv_state_d = rx_sync_q ? RCV_IDLE : RCV_DATA;
        end else begin
          rcv_cnt_d = rcv_cnt_q + 1'b1;
        end
      end
      RCV_DATA: begin
        if (rcv_cnt_q == BaudLast) begin
          rcv_cnt_d   = '0;
          rcv_shift_d = {rx_sync_q, rcv_shift_q[7:1]};
          if (rcv_bit_q == 3'd7) begin
            rcv_state_d = RCV_STOP;
          end else begin
            rcv_bit_d = rcv_bit_q + 1'b1;
          end
        end else begin
          rcv_cnt_d = rcv_cnt_q + 1'b1;
        end
      end
      RCV_STOP: begin
        if (rcv_cnt_q == BaudLast) begin
          rcv_cnt_d = '0;
          if (rx_sync_q) begin
            rx_done_d   = 1'b1;
            rx_byte_d   = rcv_shift_q;
            rcv_state_d = RCV_IDLE;
          end else begin
            rcv_state_d = RCV_RECOVER;
          end
        end else begin
          rcv_cnt_d = rcv_cnt_q + 1'b1;
        end
      end
      RCV_RECOVER: begin
        if (rx_sync_q) rcv_state_d = RCV_IDLE;
      end
      default: rcv_state_d = RCV_IDLE;
    endcase
  end

  // Control FSM; rx_done outside RX_WAIT is simply not looked at
  always_comb begin
    state_d  = state_q;
    byte_d   = byte_q;
    result_d = result_q;
    tx_start = 1'b0;
    unique case (state_q)
      RX_WAIT: begin
        if (rx_done_q) begin
          byte_d  = rx_byte_q;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        result_d = byte_q;
        state_d  = TX_START;
      end
      TX_START: begin
        tx_start = 1'b1;
        state_d  = TX_WAIT;
      end
      TX_WAIT: begin
        if (tx_done) state_d = RX_WAIT;
      end
      default: state_d = RX_WAIT;
    endcase
    cts_n_d = (state_d != RX_WAIT);
  end

  // Transmitter: bit index 0 = start, 1..8 = data, 9 = stop
  assign tx_done = tx_busy_q && (tx_cnt_q == BaudLast) && (tx_bit_q == 4'd9);

  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_out_d   = tx_out_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    if (tx_start) begin
      tx_busy_d  = 1'b1;
      tx_out_d   = 1'b0;
      tx_cnt_d   = '0;
      tx_bit_d   = '0;
      tx_shift_d = result_q;
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BaudLast) begin
        tx_cnt_d = '0;
        if (tx_bit_q == 4'd9) begin
          tx_busy_d = 1'b0;
          tx_out_d  = 1'b1;
        end else begin
          tx_bit_d = tx_bit_q + 1'b1;
          if (tx_bit_q == 4'd8) begin
            tx_out_d = 1'b1;
          end else begin
            tx_out_d   = tx_shift_q[0];
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end
      end else begin
        tx_cnt_d = tx_cnt_q + 1'b1;
      end
    end
  end

  assign tx_out              = tx_out_q;
  assign clear_to_send_out_n = cts_n_q;

endmodule

// File: tb/tb_ident_8b_uart_top.sv
// Bench for the UART echo top: directed scenarios plus random bytes, with a
// frame-decoding monitor on tx_out and a byte-level expectation model.
module tb_ident_8b_uart_top;

  localparam int C = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx_in = 1'b1;
  logic tx_out;
  logic cts_n;

  ident_8b_uart_top #(.ClocksPerBaud(C)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx_in               (rx_in),
    .tx_out              (tx_out),
    .clear_to_send_out_n (cts_n)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int t_sent = 0;

  typedef struct {
    logic [7:0] data;
    bit         ok;
    int         start;
    logic       cts_start;
    logic       cts_end;
    logic       cts_after;
  } frame_t;

  frame_t frames[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Decode every frame on tx_out, sampling each clock so bit lengths are exact
  initial begin : tx_monitor
    frame_t     f;
    logic [9:0] bits;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx_out === 1'b0) begin
        f.start     = cyc;
        f.cts_start = cts_n;
        f.ok        = 1'b1;
        f.cts_end   = 1'b0;
        aborted     = 1'b0;
        bits        = '0;
        for (int i = 0; i < 10 * C; i++) begin
          if (i > 0) @(negedge clk);
          if (rst) begin
            aborted = 1'b1;
            break;
          end
          if (i % C == 0) bits[i / C] = tx_out;
          else if (tx_out !== bits[i / C]) f.ok = 1'b0;
          if (i == 10 * C - 1) f.cts_end = cts_n;
        end
        if (!aborted) begin
          @(negedge clk);
          f.cts_after = cts_n;
          if (tx_out !== 1'b1 || bits[0] !== 1'b0 || bits[9] !== 1'b1) f.ok = 1'b0;
          f.data = bits[8:1];
          frames.push_back(f);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx_in  = 1'b0;
    t_sent = cyc;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (C) @(negedge clk);
    end
    rx_in = stop;
    repeat (C) @(negedge clk);
    rx_in = 1'b1;
  endtask

  // The echo must begin after the stop bit is sampled mid-bit plus the
  // three-cycle pipeline, and before the stop bit ends plus that pipeline.
  task automatic expect_echo(input string tag, input logic [7:0] b);
    frame_t f;
    int     n = 0;
    int     lat;
    while (frames.size() == 0 && n < 20 * C) begin
      @(negedge clk);
      n++;
    end
    if (frames.size() == 0) begin
      check_eq({tag, "_timeout"}, 32'd0, 32'd1);
      $display("echo %s: sent 0x%02h, no frame seen", tag, b);
    end else begin
      f   = frames.pop_front();
      lat = f.start - t_sent;
      check_eq({tag, "_data"}, f.data, b);
      check_eq({tag, "_framing"}, f.ok, 1);
      check_eq({tag, "_cts_start"}, f.cts_start, 1);
      check_eq({tag, "_cts_stop"}, f.cts_end, 1);
      check_eq({tag, "_cts_after"}, f.cts_after, 0);
      check_eq({tag, "_latency"}, (lat >= 9 * C + C / 2 + 1 && lat <= 10 * C + 4), 1);
      $display("echo %s: sent 0x%02h got 0x%02h latency %0d", tag, b, f.data, lat);
    end
  endtask

  task automatic expect_silence(input string tag, input int ncyc);
    int n_low = 0;
    int n_cts = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (tx_out !== 1'b1) n_low++;
      if (cts_n !== 1'b0) n_cts++;
    end
    check_eq({tag, "_frames"}, frames.size(), 0);
    check_eq({tag, "_tx_low"}, n_low, 0);
    check_eq({tag, "_cts_high"}, n_cts, 0);
    $display("quiet %s: frames %0d tx-low cycles %0d cts-high cycles %0d", tag, frames.size(), n_low, n_cts);
  endtask

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [7:0] b;
    logic       stop;
    int         n;

    repeat (4) begin
      @(negedge clk);
      check_eq("reset_tx", tx_out, 1);
      check_eq("reset_cts", cts_n, 1);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("release_cts_hold", cts_n, 1);
    @(negedge clk);
    check_eq("release_cts_low", cts_n, 0);
    check_eq("release_tx_idle", tx_out, 1);
    $display("reset: released, cts_n %0b tx_out %0b", cts_n, tx_out);
    expect_silence("idle", 4 * C);

    send_byte(8'h55, 1'b1);
    expect_echo("x55", 8'h55);

    send_byte(8'h00, 1'b1);
    expect_echo("x00", 8'h00);
    send_byte(8'hFF, 1'b1);
    expect_echo("xFF", 8'hFF);

    @(negedge clk);
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    expect_silence("glitch", 4 * C);

    send_byte(8'hA5, 1'b0);
    expect_silence("framing", 4 * C);
    send_byte(8'h3C, 1'b1);
    expect_echo("x3C_after_framing", 8'h3C);

    // Reset in the middle of data bit 3 of an outgoing frame
    send_byte(8'h96, 1'b1);
    n = 0;
    while (tx_out !== 1'b0 && n < 8 * C) begin
      @(negedge clk);
      n++;
    end
    check_eq("midtx_started", tx_out, 0);
    repeat (4 * C + C / 2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midtx_tx_high", tx_out, 1);
    check_eq("midtx_cts_high", cts_n, 1);
    repeat (3) @(negedge clk);
    check_eq("midtx_aborted", frames.size(), 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midtx_cts_low", cts_n, 0);
    $display("reset mid-transmit: tx_out %0b cts_n %0b after release", tx_out, cts_n);
    send_byte(8'hC3, 1'b1);
    expect_echo("xC3_after_reset", 8'hC3);

    // Random bytes; a frame with a bad stop bit must produce no echo
    for (int k = 0; k < 12; k++) begin
      b    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 3 * C)) @(negedge clk);
      send_byte(b, stop);
      if (stop) expect_echo($sformatf("rand%0d", k), b);
      else expect_silence($sformatf("rand%0d_badstop", k), 4 * C);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
